// File: rtl/user_btn_decoder_if.sv
// Button decoder bus: the raw pin going in and the conditioned
// level/event pulses coming out. The decoder uses the slave modport;
// whatever drives the pin and consumes the events uses the master modport.
interface user_btn_decoder_if;
  logic USER_BTN;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;

  modport master (
    output USER_BTN,
    input  btn_level, press_pulse, release_pulse, short_pulse,
           long_pulse, repeat_pulse
  );

  modport slave (
    input  USER_BTN,
    output btn_level, press_pulse, release_pulse, short_pulse,
           long_pulse, repeat_pulse
  );
endinterface

// File: rtl/user_btn_decoder.sv
// user_btn_decoder: turns the raw board push-button into a debounced level
// and single-cycle press / release / short / long events on CLK12M.
// Optional auto-repeat while long-held is built only when the macro
// BTN_AUTOREPEAT_EN is defined; otherwise repeat_pulse is tied to 0.
module user_btn_decoder #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 6000000,
  parameter int REPEAT_CYCLES   = 1200000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic                 CLK12M,
  input  logic                 reset,
  user_btn_decoder_if.slave    bus
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

  // Reject parameter sets for which the counters cannot express their limits.
  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 2)
  begin : g_bad_params
    $error("user_btn_decoder: illegal cycle parameters");
  end

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    LONG,
    DEB_RELEASE
  } state_t;

  state_t              state;
  logic                sync1, sync2;
  logic                raw_s;
  logic [DEB_W-1:0]    deb_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                long_flag;
  logic                level_q;
  logic                press_q, release_q, short_q, long_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt;
  logic             repeat_q;
`endif

  // Two-flop synchronizer; both flops idle at the unpressed pin level.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge CLK12M or posedge reset) begin
    if (reset) begin
      sync1 <= BTN_ACTIVE_LOW;
      sync2 <= BTN_ACTIVE_LOW;
    end else begin
      sync1 <= bus.USER_BTN;
      sync2 <= sync1;
    end
  end

  // Normalise polarity: raw_s = 1 means the button is pressed.
  assign raw_s = sync2 ^ BTN_ACTIVE_LOW;

  // Debounce / hold FSM with all outputs registered; pulses self-clear.
  always_ff @(posedge CLK12M or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      long_flag <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt   <= '0;
      repeat_q  <= 1'b0;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (raw_s) begin
            state   <= DEB_PRESS;
            deb_cnt <= '0;
          end
        end
        DEB_PRESS: begin
          if (!raw_s) begin
            state <= IDLE;
          end else if (deb_cnt == DEB_MAX) begin
            state     <= PRESSED;
            level_q   <= 1'b1;
            press_q   <= 1'b1;
            hold_cnt  <= '0;
            long_flag <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end
        PRESSED: begin
          // A release candidate wins over the hold limit; hold_cnt freezes.
          if (!raw_s) begin
            state   <= DEB_RELEASE;
            deb_cnt <= '0;
          end else if (hold_cnt == HOLD_MAX) begin
            state     <= LONG;
            long_q    <= 1'b1;
            long_flag <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        LONG: begin
          if (!raw_s) begin
            state   <= DEB_RELEASE;
            deb_cnt <= '0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (rep_cnt == REP_MAX) begin
            repeat_q <= 1'b1;
            rep_cnt  <= '0;
          end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
          end
`endif
        end
        DEB_RELEASE: begin
          // A bounce back to pressed resumes the hold where it left off.
          if (raw_s) begin
            state <= long_flag ? LONG : PRESSED;
          end else if (deb_cnt == DEB_MAX) begin
            state     <= IDLE;
            level_q   <= 1'b0;
            release_q <= 1'b1;
            short_q   <= !long_flag;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.short_pulse   = short_q;
  assign bus.long_pulse    = long_q;
`ifdef BTN_AUTOREPEAT_EN
  assign bus.repeat_pulse  = repeat_q;
`else
  assign bus.repeat_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_user_btn_decoder.sv
// Directed bench for user_btn_decoder with a cycle-stamped event scoreboard.
// Each step pushes the events it must cause (cycle, pulse set, level); a
// negedge monitor pops and compares whenever a pulse appears or an event is due.
module tb_user_btn_decoder;

  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 8;

  // Pulse vector order: {press, release, short, long, repeat}
  localparam logic [4:0] P_PRESS = 5'b10000;
  localparam logic [4:0] P_REL   = 5'b01000;
  localparam logic [4:0] P_SHORT = 5'b00100;
  localparam logic [4:0] P_LONG  = 5'b00010;
  localparam logic [4:0] P_REP   = 5'b00001;

  typedef struct {
    int         cyc;
    logic [4:0] pulses;
    logic       level;
  } ev_t;

  logic CLK12M = 1'b0;
  logic reset;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  ev_t  sb[$];
  ev_t  ev_m;
  logic [4:0] obs_m;
  int   b;

  user_btn_decoder_if bus ();

  user_btn_decoder #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LNG),
    .REPEAT_CYCLES   (REP),
    .BTN_ACTIVE_LOW  (1'b1)
  ) dut (
    .CLK12M (CLK12M),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 CLK12M = ~CLK12M;

  // Edge counter: after posedge k (sampled at +1 or on the negedge) cyc == k.
  always @(posedge CLK12M) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input int c, input logic [4:0] p, input logic lvl);
    ev_t e;
    e.cyc    = c;
    e.pulses = p;
    e.level  = lvl;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] all_outputs();
    return {26'd0, bus.btn_level, bus.press_pulse, bus.release_pulse,
            bus.short_pulse, bus.long_pulse, bus.repeat_pulse};
  endfunction

  // Return just after an edge, with base = that edge's number.
  task automatic at_edge(output int base);
    @(posedge CLK12M);
    #1;
    base = cyc;
  endtask

  // Advance to just after edge base+k.
  task automatic to_edge(input int base, input int k);
    while (cyc < base + k) begin
      @(posedge CLK12M);
      #1;
    end
  endtask

  // Wait (bounded) for every expected event to be consumed, then idle a bit
  // so a late spurious pulse is still caught.
  task automatic drain(input string tag);
    int budget = 100;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge CLK12M);
      #1;
      budget--;
    end
    check(tag, 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (6) @(posedge CLK12M);
    #1;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge CLK12M) begin
    obs_m = {bus.press_pulse, bus.release_pulse, bus.short_pulse,
             bus.long_pulse, bus.repeat_pulse};
    if (obs_m != 5'b0 || (sb.size() > 0 && sb[0].cyc <= cyc)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {27'd0, obs_m}, 32'd0);
      end else begin
        ev_m = sb.pop_front();
        check("event_cycle", 32'(cyc), 32'(ev_m.cyc));
        check("event_pulses", {27'd0, obs_m}, {27'd0, ev_m.pulses});
        check("event_level", {31'd0, bus.btn_level}, {31'd0, ev_m.level});
      end
    end
  end

  initial begin
    reset        = 1'b0;
    bus.USER_BTN = 1'b1;

    // Reset asserted between edges: outputs clear without a clock edge.
    #2 reset = 1'b1;
    #1 check("reset_async_outputs", all_outputs(), 32'd0);
    repeat (3) @(posedge CLK12M);
    #3 reset = 1'b0;
    at_edge(b);
    to_edge(b, 10);
    check("idle_level_after_reset", {31'd0, bus.btn_level}, 32'd0);
    drain("drain_after_reset");

    // Short press: 12 cycles low.
    at_edge(b);
    bus.USER_BTN = 1'b0;
    expect_ev(b + 7,  P_PRESS, 1'b1);
    expect_ev(b + 19, P_REL | P_SHORT, 1'b0);
    to_edge(b, 10);
    check("short_level_held", {31'd0, bus.btn_level}, 32'd1);
    to_edge(b, 12);
    bus.USER_BTN = 1'b1;
    drain("drain_short");

    // Bounce shorter than the debounce window: nothing happens.
    at_edge(b);
    bus.USER_BTN = 1'b0;
    to_edge(b, 3);
    bus.USER_BTN = 1'b1;
    to_edge(b, 5);
    check("bounce_level_mid", {31'd0, bus.btn_level}, 32'd0);
    to_edge(b, 14);
    check("bounce_level_end", {31'd0, bus.btn_level}, 32'd0);
    drain("drain_bounce");

    // Long press: 40 cycles held.
    at_edge(b);
    bus.USER_BTN = 1'b0;
    expect_ev(b + 7,  P_PRESS, 1'b1);
    expect_ev(b + 27, P_LONG, 1'b1);
`ifdef BTN_AUTOREPEAT_EN
    expect_ev(b + 35, P_REP, 1'b1);
`endif
    expect_ev(b + 47, P_REL, 1'b0);
    to_edge(b, 30);
    check("long_level_held", {31'd0, bus.btn_level}, 32'd1);
    to_edge(b, 40);
    bus.USER_BTN = 1'b1;
    drain("drain_long");

    // Glitch while PRESSED: pin high after edge 10 until after edge 12.
    // hold_cnt stays frozen for the glitch plus the return cycle, so long
    // moves from edge 27 to edge 30; no release, one press.
    at_edge(b);
    bus.USER_BTN = 1'b0;
    expect_ev(b + 7,  P_PRESS, 1'b1);
    expect_ev(b + 30, P_LONG, 1'b1);
    expect_ev(b + 39, P_REL, 1'b0);
    to_edge(b, 10);
    bus.USER_BTN = 1'b1;
    to_edge(b, 12);
    bus.USER_BTN = 1'b0;
    to_edge(b, 16);
    check("glitch_level_held", {31'd0, bus.btn_level}, 32'd1);
    to_edge(b, 32);
    bus.USER_BTN = 1'b1;
    drain("drain_glitch");

    // Hold 50 cycles: repeats 8/16/24 after long only with the feature.
    at_edge(b);
    bus.USER_BTN = 1'b0;
    expect_ev(b + 7,  P_PRESS, 1'b1);
    expect_ev(b + 27, P_LONG, 1'b1);
`ifdef BTN_AUTOREPEAT_EN
    expect_ev(b + 35, P_REP, 1'b1);
    expect_ev(b + 43, P_REP, 1'b1);
    expect_ev(b + 51, P_REP, 1'b1);
`endif
    expect_ev(b + 57, P_REL, 1'b0);
    to_edge(b, 50);
    bus.USER_BTN = 1'b1;
    drain("drain_repeat");

    // Reset mid-press, button kept down: fresh press after a full debounce.
    at_edge(b);
    bus.USER_BTN = 1'b0;
    expect_ev(b + 7, P_PRESS, 1'b1);
    to_edge(b, 12);
    check("midpress_level_before_reset", {31'd0, bus.btn_level}, 32'd1);
    #2 reset = 1'b1;
    #1 check("midpress_async_outputs", all_outputs(), 32'd0);
    check("midpress_queue_empty", 32'(sb.size()), 32'd0);
    to_edge(b, 15);
    reset = 1'b0;
    expect_ev(b + 22, P_PRESS, 1'b1);
    expect_ev(b + 33, P_REL | P_SHORT, 1'b0);
    to_edge(b, 26);
    bus.USER_BTN = 1'b1;
    drain("drain_reset_midpress");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
